fifo_ctrl: RTL and testbench

- Pointer/flag controller that turns the 2**W-entry register file into a circular FIFO.
- Generates the register file's write enable, write address and read address.
- Tracks occupancy; reports full/empty, almost-full/almost-empty and sticky overflow/underflow errors.
- Top level instantiates fifo_ctrl beside reg_file, sharing W; data never passes through this block.

---
 rtl/fifo_ctrl.sv | 65 ++++++
 tb/tb_fifo_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller that turns a 2**W-entry register file into a
// first-word-fall-through circular FIFO. Data never passes through here.
module fifo_ctrl #(
  parameter int W        = 2,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic         clr_err,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [W:0] DEPTH = (W+1)'(2**W);
  localparam logic [W:0] AF_L  = (W+1)'(AF_LEVEL);
  localparam logic [W:0] AE_L  = (W+1)'(AE_LEVEL);

  logic         do_wr, do_rd;
  logic [W:0]   count_next;

  // A push into a full FIFO is allowed when a pop frees the head slot on the same edge.
  assign do_wr = wr & (~full | rd);
  assign do_rd = rd & ~empty;
  assign wr_en = do_wr;

  assign count_next = count + {{W{1'b0}}, do_wr} - {{W{1'b0}}, do_rd};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_addr       <= '0;
      r_addr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (AF_LEVEL == 0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (do_wr) w_addr <= w_addr + 1'b1;
      if (do_rd) r_addr <= r_addr + 1'b1;
      count        <= count_next;
      // Flags come from count_next so they line up with count on the same edge.
      full         <= (count_next == DEPTH);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_L);
      almost_empty <= (count_next <= AE_L);
      // A new error in the same cycle as clr_err wins over the clear.
      overflow     <= (wr & full & ~rd) | (overflow  & ~clr_err);
      underflow    <= (rd & empty)      | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed, table-driven check of fifo_ctrl (W=2, AF_LEVEL=3, AE_LEVEL=1)
// plus a hand-written asynchronous reset sequence.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr, rd, clr_err;
  logic       wr_en;
  logic [1:0] w_addr, r_addr;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] count;
  logic       overflow, underflow;

  int n_checks = 0;
  int n_fails  = 0;

  fifo_ctrl #(.W(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
    .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr, rd, clr;
    logic        exp_wen;
    logic [12:0] exp_st;
  } vec_t;

  vec_t vecs[18];

  // State bundle: {count, full, empty, almost_full, almost_empty, w_addr, r_addr, overflow, underflow}
  function automatic logic [12:0] st(int cnt, int f, int e, int af, int ae,
                                     int wa, int ra, int ov, int un);
    logic [2:0] c3;
    logic [1:0] w2, r2;
    c3 = 3'(cnt); w2 = 2'(wa); r2 = 2'(ra);
    return {c3, f[0], e[0], af[0], ae[0], w2, r2, ov[0], un[0]};
  endfunction

  function automatic vec_t mk(int w, int r, int c, int wen, logic [12:0] s);
    vec_t v;
    v.wr = w[0]; v.rd = r[0]; v.clr = c[0]; v.exp_wen = wen[0]; v.exp_st = s;
    return v;
  endfunction

  function automatic logic [12:0] act_st();
    return {count, full, empty, almost_full, almost_empty, w_addr, r_addr, overflow, underflow};
  endfunction

  task automatic check_st(string name, int idx, logic [12:0] exp);
    logic [12:0] a;
    a = act_st();
    n_checks++;
    if (a !== exp) begin
      n_fails++;
      $display("FAIL %s[%0d]: got cnt=%0d f=%b e=%b af=%b ae=%b wa=%0d ra=%0d ov=%b un=%b, want cnt=%0d f=%b e=%b af=%b ae=%b wa=%0d ra=%0d ov=%b un=%b",
               name, idx, a[12:10], a[9], a[8], a[7], a[6], a[5:4], a[3:2], a[1], a[0],
               exp[12:10], exp[9], exp[8], exp[7], exp[6], exp[5:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_wen(string name, int idx, logic exp);
    n_checks++;
    if (wr_en !== exp) begin
      n_fails++;
      $display("FAIL %s[%0d]: wr_en got %b want %b", name, idx, wr_en, exp);
    end
  endtask

  task automatic step(logic w, logic r, logic c);
    @(negedge clk);
    wr = w; rd = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // fill, overflow + clear, full pass-through, drain, empty wr&rd, error clear priority
    vecs[0]  = mk(0,0,0, 0, st(0,0,1,0,1, 0,0, 0,0));
    vecs[1]  = mk(1,0,0, 1, st(1,0,0,0,1, 1,0, 0,0));
    vecs[2]  = mk(1,0,0, 1, st(2,0,0,0,0, 2,0, 0,0));
    vecs[3]  = mk(1,0,0, 1, st(3,0,0,1,0, 3,0, 0,0));
    vecs[4]  = mk(1,0,0, 1, st(4,1,0,1,0, 0,0, 0,0));
    vecs[5]  = mk(1,0,0, 0, st(4,1,0,1,0, 0,0, 1,0));
    vecs[6]  = mk(0,0,1, 0, st(4,1,0,1,0, 0,0, 0,0));
    vecs[7]  = mk(1,1,0, 1, st(4,1,0,1,0, 1,1, 0,0));
    vecs[8]  = mk(1,1,0, 1, st(4,1,0,1,0, 2,2, 0,0));
    vecs[9]  = mk(1,1,0, 1, st(4,1,0,1,0, 3,3, 0,0));
    vecs[10] = mk(0,1,0, 0, st(3,0,0,1,0, 3,0, 0,0));
    vecs[11] = mk(0,1,0, 0, st(2,0,0,0,0, 3,1, 0,0));
    vecs[12] = mk(0,1,0, 0, st(1,0,0,0,1, 3,2, 0,0));
    vecs[13] = mk(0,1,0, 0, st(0,0,1,0,1, 3,3, 0,0));
    vecs[14] = mk(1,1,0, 1, st(1,0,0,0,1, 0,3, 0,1));
    vecs[15] = mk(0,1,0, 0, st(0,0,1,0,1, 0,0, 0,1));
    vecs[16] = mk(0,1,1, 0, st(0,0,1,0,1, 0,0, 0,1));
    vecs[17] = mk(0,0,1, 0, st(0,0,1,0,1, 0,0, 0,0));

    reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_st("reset", 0, st(0,0,1,0,1, 0,0, 0,0));
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      wr = vecs[i].wr; rd = vecs[i].rd; clr_err = vecs[i].clr;
      #1;
      check_wen("vec_wen", i, vecs[i].exp_wen);
      @(posedge clk);
      #1;
      check_st("vec", i, vecs[i].exp_st);
    end

    // Push 3, pop 1, then reset between edges must clear without a clock.
    step(1,0,0); step(1,0,0); step(1,0,0);
    step(0,1,0);
    check_st("pre_areset", 0, st(2,0,0,0,0, 3,1, 0,0));
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_st("areset", 0, st(0,0,1,0,1, 0,0, 0,0));
    check_wen("areset_wen", 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1,0,0);
    check_st("post_reset", 0, st(1,0,0,0,1, 1,0, 0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
